// File: rtl/mul2_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul2_share_ctrl: two-port round-robin arbiter and sequencer that builds     |
// | 4x4-bit unsigned products from four passes through one 2x2-bit multiplier.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mul2_share_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_p,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [1:0] r_step;
  logic [7:0] r_acc;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_id;
  logic       r_rr;
  logic       r_res_valid;
  logic [7:0] r_res_p;
  logic       r_res_id;
  logic       r_busy;

  logic       w_idle;
  logic       w_grant;
  logic       w_accept;
  logic [3:0] w_sel_a;
  logic [3:0] w_sel_b;
  logic       w_last_step;
  logic [1:0] w_da;
  logic [1:0] w_db;
  logic [3:0] w_pp;
  logic [7:0] w_pp_sh;
  logic [7:0] w_acc_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester always wins, a tie goes to the rr pointer.
  // ---------------------------------------------------------------------------
  assign w_idle = (r_state == S_IDLE);

  always_comb begin
    w_grant = r_rr;
    if (req0_valid && !req1_valid) begin
      w_grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready = w_idle && !w_grant && rst_n;
  assign req1_ready = w_idle &&  w_grant && rst_n;
  assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign w_sel_a = w_grant ? req1_a : req0_a;
  assign w_sel_b = w_grant ? req1_b : req0_b;

  // ---------------------------------------------------------------------------
  // Shared 2x2 datapath: step[0] picks the a digit, step[1] picks the b digit,
  // so the shift is twice the number of high digits in play.
  // ---------------------------------------------------------------------------
  assign w_da        = r_step[0] ? r_a[3:2] : r_a[1:0];
  assign w_db        = r_step[1] ? r_b[3:2] : r_b[1:0];
  assign w_pp        = {2'b00, w_da} * {2'b00, w_db};
  assign w_last_step = (r_step == 2'd3);

  always_comb begin
    w_pp_sh = {4'b0000, w_pp};
    case (r_step)
      2'd0:    w_pp_sh = {4'b0000, w_pp};
      2'd1:    w_pp_sh = {2'b00, w_pp, 2'b00};
      2'd2:    w_pp_sh = {2'b00, w_pp, 2'b00};
      default: w_pp_sh = {w_pp, 4'b0000};
    endcase
  end

  assign w_acc_nxt = r_acc + w_pp_sh;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last_step) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (r_res_valid && res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers, accumulator and result holding registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= 2'd0;
      r_acc       <= 8'd0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_id        <= 1'b0;
      r_rr        <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_p     <= 8'd0;
      r_res_id    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_id   <= w_grant;
            r_rr   <= ~r_rr;
            r_acc  <= 8'd0;
            r_step <= 2'd0;
          end
        end
        S_CALC: begin
          r_acc  <= w_acc_nxt;
          r_step <= r_step + 2'd1;
          if (w_last_step) begin
            r_res_p     <= w_acc_nxt;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_p     = r_res_p;
  assign res_id    = r_res_id;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul2_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul2_share_ctrl: directed and exhaustive checks of mul2_share_ctrl       |
// | against a cycle-counting behavioural model.                                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mul2_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = 4'd0;
  logic [3:0] req0_b = 4'd0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = 4'd0;
  logic [3:0] req1_b = 4'd0;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_p;
  logic       res_id;
  logic       res_ready = 1'b1;
  logic       busy;

  always #5 clk = ~clk;

  mul2_share_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_p      (res_p),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester job queues ({a,b}) and per-port expected products in issue order
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         expq0[$];
  int         expq1[$];
  logic [8:0] seen[$];

  task automatic push(input int port, input int a, input int b);
    logic [3:0] a4;
    logic [3:0] b4;
    a4 = a[3:0];
    b4 = b[3:0];
    if (port == 0) begin
      q0.push_back({a4, b4});
      expq0.push_back(a * b);
    end else begin
      q1.push_back({a4, b4});
      expq1.push_back(a * b);
    end
  endtask

  // Requester drivers: hold a job until it is accepted, then move to the next
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;
  always @(negedge clk) begin
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
  end

  always @(posedge clk) begin
    #3;
    if (acc0 && q0.size() > 0) q0.delete(0);
    if (acc1 && q1.size() > 0) q1.delete(0);
    if (q0.size() > 0) begin
      req0_valid = 1'b1;
      {req0_a, req0_b} = q0[0];
    end else begin
      req0_valid = 1'b0;
    end
    if (q1.size() > 0) begin
      req1_valid = 1'b1;
      {req1_a, req1_b} = q1[0];
    end else begin
      req1_valid = 1'b0;
    end
  end

  // Behavioural model: idle / counting edges since accept / result held
  bit m_idle = 1'b1;
  bit m_rv   = 1'b0;
  bit m_rr   = 1'b0;
  bit m_id   = 1'b0;
  bit m_rid  = 1'b0;
  int m_cnt  = 0;
  int m_p    = 0;
  int m_rp   = 0;

  function automatic bit m_grant();
    if (req0_valid && !req1_valid) return 1'b0;
    if (req1_valid && !req0_valid) return 1'b1;
    return m_rr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_rv   = 1'b0;
      m_rr   = 1'b0;
      m_cnt  = 0;
    end else if (m_idle) begin
      if ((req0_valid && !m_grant()) || (req1_valid && m_grant())) begin
        m_id   = m_grant();
        m_p    = m_id ? int'(req1_a) * int'(req1_b) : int'(req0_a) * int'(req0_b);
        m_idle = 1'b0;
        m_cnt  = 0;
        m_rr   = !m_rr;
      end
    end else if (!m_rv) begin
      m_cnt++;
      if (m_cnt == 4) begin
        m_rv  = 1'b1;
        m_rp  = m_p;
        m_rid = m_id;
      end
    end else if (res_ready) begin
      m_rv   = 1'b0;
      m_idle = 1'b1;
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    chk("req0_ready", req0_ready, int'(rst_n && m_idle && !m_grant()));
    chk("req1_ready", req1_ready, int'(rst_n && m_idle && m_grant()));
    chk("busy", busy, int'(!m_idle));
    chk("res_valid", res_valid, int'(m_rv));
    if (m_rv) begin
      chk("res_p", res_p, m_rp);
      chk("res_id", res_id, int'(m_rid));
    end
  end

  // Result monitor: each port's results must come back in order with a*b
  always @(negedge clk) begin
    #1;
    if (rst_n && res_valid && res_ready) begin
      seen.push_back({res_id, res_p});
      if (res_id == 1'b0) begin
        chk("port0 result expected", expq0.size() > 0, 1);
        if (expq0.size() > 0) begin
          chk("port0 product", res_p, expq0[0]);
          expq0.delete(0);
        end
      end else begin
        chk("port1 result expected", expq1.size() > 0, 1);
        if (expq1.size() > 0) begin
          chk("port1 product", res_p, expq1[0]);
          expq1.delete(0);
        end
      end
    end
  end

  function automatic bit all_quiet();
    return (q0.size() == 0) && (q1.size() == 0) && m_idle && !req0_valid && !req1_valid;
  endfunction

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (!all_quiet() && n < limit) begin
      @(posedge clk);
      #4;
      n++;
    end
    chk("drain within budget", n < limit, 1);
  endtask

  // Issue one job, check accept wait, 4-edge latency and literal result
  task automatic run_single(input int port, input int a, input int b, input int exp_p,
                            output int waited);
    int t0;
    bit got;
    push(port, a, b);
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
      got = (port == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    chk("accept seen", got, 1);
    @(posedge clk);
    #2;
    t0 = cyc;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = res_valid;
    end
    chk("accept-to-result edges", cyc - t0, 4);
    chk("literal res_p", res_p, exp_p);
    chk("literal res_id", res_id, port);
    if (res_ready) begin
      @(posedge clk);
      #1;
      chk("idle one edge after take", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    int budget;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_p", res_p, 0);
    chk("reset res_id", res_id, 0);
    chk("reset req0_ready", req0_ready, 0);
    chk("reset req1_ready", req1_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Smallest case: accepted in the first cycle it is presented
    run_single(0, 3, 2, 6, waited);
    chk("first-cycle accept", waited, 1);
    wait_drain(50);

    // Largest case
    run_single(1, 15, 15, 225, waited);
    wait_drain(50);

    // Zero product held under backpressure; a pending request must wait
    @(posedge clk);
    #2 res_ready = 1'b0;
    run_single(0, 0, 9, 0, waited);
    push(1, 4, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall res_valid", res_valid, 1);
      chk("stall res_p", res_p, 0);
      chk("stall req1_ready", req1_ready, 0);
    end
    @(posedge clk);
    #2 res_ready = 1'b1;
    wait_drain(50);

    // Reset in CALC step 2 aborts the job
    push(1, 9, 9);
    waited = 0;
    while (!(req1_valid && req1_ready) && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort res_valid", res_valid, 0);
    chk("abort res_p", res_p, 0);
    chk("abort res_id", res_id, 0);
    chk("abort req0_ready", req0_ready, 0);
    chk("abort req1_ready", req1_ready, 0);
    q0.delete();
    q1.delete();
    expq0.delete();
    expq1.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Re-present alongside a tie: rr restarts at 0 so req0 goes first
    seen.delete();
    push(0, 5, 7);
    push(1, 9, 9);
    wait_drain(100);
    chk("tie result count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("tie first {id,p}", int'(seen[0]), 35);
      chk("tie second {id,p}", int'(seen[1]), 256 + 81);
    end

    // Continuous contention alternates 0,1,0,1...
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 5, 7);
      push(1, 12, 3);
    end
    wait_drain(200);
    chk("contention result count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      chk("contention {id,p}", int'(seen[i]), (i % 2 == 0) ? 35 : 256 + 36);
    end

    // All 256 operand pairs across both ports with random consumer stalls
    seen.delete();
    for (int k = 0; k < 256; k++) begin
      push(k % 2, k / 16, k % 16);
    end
    budget = 0;
    while (!all_quiet() && budget < 20000) begin
      @(posedge clk);
      #2 res_ready = ($urandom_range(0, 3) != 0);
      budget++;
    end
    res_ready = 1'b1;
    wait_drain(50);
    chk("exhaustive result count", seen.size(), 256);
    chk("port0 leftovers", expq0.size(), 0);
    chk("port1 leftovers", expq1.size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
